// File: rtl/dmem_responder_if.sv
// Load/store bus between the core (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        memread;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [3:0]  byteen;
  logic [31:0] readdata;
  logic        done;
  logic        busy;
  logic        err;

  modport master (
    output memread, memwrite, dataadr, writedata, byteen,
    input  readdata, done, busy, err
  );

  modport slave (
    input  memread, memwrite, dataadr, writedata, byteen,
    output readdata, done, busy, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte enables and programmable wait states.
// Define DMEM_WRCOUNT_EN to add a committed-store counter mapped at 0xFFFFFFF0.
module dmem_responder #(
  parameter int unsigned DEPTH_LOG2  = 6,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);
  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [3:0]  WS     = 4'(WAIT_STATES);
  localparam logic [31:0] CSR_AD = 32'hFFFF_FFF0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [3:0]  be;
  } req_t;

  logic [1:0]            state;
  logic [3:0]            cnt;
  req_t                  req_q, req_in, req_c;
  logic [31:0]           mem [DEPTH];
  logic                  accept, commit;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  in_range, aligned, conflict, csr_hit, dec_err;
  logic                  done_q, err_q;
  logic [31:0]           rdata_q;

  assign req_in = '{rd: bus.memread, wr: bus.memwrite, adr: bus.dataadr,
                    wd: bus.writedata, be: bus.byteen};

  assign accept = (state == S_IDLE) && (bus.memread || bus.memwrite);

  // With zero wait states the commit lands on the accept edge, so decode the live bus.
  assign req_c  = (state == S_IDLE) ? req_in : req_q;
  assign commit = !reset && ((accept && (WS == 4'd0)) ||
                             ((state == S_WAIT) && (cnt <= 4'd1)));

  assign idx      = req_c.adr[DEPTH_LOG2+1:2];
  assign in_range = (req_c.adr >> (DEPTH_LOG2 + 2)) == 32'd0;
  assign aligned  = req_c.adr[1:0] == 2'b00;
  assign conflict = req_c.rd && req_c.wr;
`ifdef DMEM_WRCOUNT_EN
  assign csr_hit  = req_c.adr == CSR_AD;
`else
  assign csr_hit  = 1'b0;
`endif
  assign dec_err  = conflict || (!csr_hit && (!in_range || !aligned));

`ifdef DMEM_WRCOUNT_EN
  logic [31:0] wrcnt;

  // The clearing store is not counted; byteen=0 stores still count.
  always_ff @(posedge clk) begin
    if (reset)
      wrcnt <= 32'd0;
    else if (commit && req_c.wr && !dec_err)
      wrcnt <= csr_hit ? 32'd0 : wrcnt + 32'd1;
  end
`endif

  // RAM is deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit && req_c.wr && !dec_err && !csr_hit) begin
      for (int b = 0; b < 4; b++)
        if (req_c.be[b])
          mem[idx][8*b +: 8] <= req_c.wd[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      req_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          req_q <= req_in;
          cnt   <= WS;
          err_q <= 1'b0;
          state <= (WS == 4'd0) ? S_RESP : S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      // Placed after the accept path so a same-edge commit overrides the err clear.
      if (commit) begin
        done_q <= 1'b1;
        err_q  <= dec_err;
        if (dec_err)
          rdata_q <= 32'd0;
        else if (req_c.rd) begin
`ifdef DMEM_WRCOUNT_EN
          rdata_q <= csr_hit ? wrcnt : mem[idx];
`else
          rdata_q <= mem[idx];
`endif
        end
      end
    end
  end

  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.readdata = rdata_q;
  assign bus.busy     = state != S_IDLE;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed cases plus randomized traffic
// compared against a word-array reference model.
module tb_dmem_responder;
  localparam int          WS     = 2;
  localparam int          DL2    = 6;
  localparam int          DEPTH  = 1 << DL2;
  localparam logic [31:0] CSR_AD = 32'hFFFF_FFF0;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_rd;
  logic [31:0] m_cnt;

  dmem_responder_if bus();

  dmem_responder #(.DEPTH_LOG2(DL2), .WAIT_STATES(WS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: applies one request to the word array and counter.
  task automatic model(input bit rd, input bit wr, input logic [31:0] adr,
                       input logic [31:0] wd, input logic [3:0] be, output bit e);
    e = rd && wr;
`ifdef DMEM_WRCOUNT_EN
    if (!e && adr == CSR_AD) begin
      if (rd) m_rd = m_cnt;
      else    m_cnt = 32'd0;
      return;
    end
`endif
    if (!e) e = (adr % 4 != 0) || (adr >= 32'(4 * DEPTH));
    if (e) begin
      m_rd = 32'd0;
      return;
    end
    if (rd) m_rd = m_mem[adr / 4];
    else begin
      for (int b = 0; b < 4; b++)
        if (be[b]) m_mem[adr / 4][8*b +: 8] = wd[8*b +: 8];
      m_cnt = m_cnt + 32'd1;
    end
  endtask

  // Issues one request from a negedge and follows it to the first IDLE cycle after done.
  task automatic xfer(input bit rd, input bit wr, input logic [31:0] adr,
                      input logic [31:0] wd, input logic [3:0] be,
                      output int lat, output bit bsy_ok, output logic e_o,
                      output logic [31:0] rd_o, output logic dn2,
                      output bit e_x, output logic [31:0] rd_x);
    bus.memread = rd; bus.memwrite = wr; bus.dataadr = adr;
    bus.writedata = wd; bus.byteen = be;
    @(posedge clk);
    @(negedge clk);
    bus.memread = 1'b0; bus.memwrite = 1'b0;
    lat = -1; bsy_ok = 1'b1; e_o = 1'bx; rd_o = 'x;
    for (int i = 1; i <= WS + 20; i++) begin
      if (bus.busy !== 1'b1) bsy_ok = 1'b0;
      if (bus.done === 1'b1) begin
        lat = i; e_o = bus.err; rd_o = bus.readdata;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    dn2 = bus.done;
    model(rd, wr, adr, wd, be, e_x);
    rd_x = m_rd;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.memread = 1'b0; bus.memwrite = 1'b0; bus.dataadr = '0;
    bus.writedata = '0; bus.byteen = '0;
    m_rd = 32'd0; m_cnt = 32'd0;
    repeat (3) @(negedge clk);
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", bus.done); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", bus.err); end
    total++; if (bus.readdata !== 32'd0) begin bad++; $display("FAIL rst_rdata got=%h want=0", bus.readdata); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat; bit bo, ex; logic eo, dn; logic [31:0] ro, rx;
    xfer(0, 1, 32'h14, 32'd21, 4'hF, lat, bo, eo, ro, dn, ex, rx);
    total++; if (lat !== WS + 1) begin bad++; $display("FAIL basic_st_lat got=%0d want=%0d", lat, WS + 1); end
    total++; if (bo !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", bo); end
    total++; if (eo !== 1'b0) begin bad++; $display("FAIL basic_st_err got=%b want=0", eo); end
    total++; if (dn !== 1'b0) begin bad++; $display("FAIL basic_done_1cyc got=%b want=0", dn); end
    xfer(1, 0, 32'h14, 32'd0, 4'h0, lat, bo, eo, ro, dn, ex, rx);
    total++; if (lat !== WS + 1) begin bad++; $display("FAIL basic_ld_lat got=%0d want=%0d", lat, WS + 1); end
    total++; if (ro !== 32'd21) begin bad++; $display("FAIL basic_ld_data got=%h want=%h", ro, 32'd21); end
    total++; if (eo !== 1'b0) begin bad++; $display("FAIL basic_ld_err got=%b want=0", eo); end
  endtask

  task automatic test_byteen();
    int lat; bit bo, ex; logic eo, dn; logic [31:0] ro, rx;
    xfer(0, 1, 32'h18, 32'h5500_00FF, 4'hF, lat, bo, eo, ro, dn, ex, rx);
    xfer(0, 1, 32'h18, 32'hAABB_CCDD, 4'b0100, lat, bo, eo, ro, dn, ex, rx);
    total++; if (ro !== 32'd21) begin bad++; $display("FAIL be_st_keeps_rdata got=%h want=%h", ro, 32'd21); end
    xfer(1, 0, 32'h18, 32'd0, 4'h0, lat, bo, eo, ro, dn, ex, rx);
    total++; if (ro !== 32'h55BB_00FF) begin bad++; $display("FAIL be_merge got=%h want=55bb00ff", ro); end
  endtask

  task automatic test_errors();
    int lat; bit bo, ex; logic eo, dn; logic [31:0] ro, rx;
    xfer(0, 1, 32'h0, 32'h0000_1234, 4'hF, lat, bo, eo, ro, dn, ex, rx);
    xfer(1, 0, 32'h102, 32'd0, 4'h0, lat, bo, eo, ro, dn, ex, rx);
    total++; if (eo !== 1'b1) begin bad++; $display("FAIL misalign_err got=%b want=1", eo); end
    total++; if (ro !== 32'd0) begin bad++; $display("FAIL misalign_rdata got=%h want=0", ro); end
    xfer(0, 1, 32'h400, 32'd7, 4'hF, lat, bo, eo, ro, dn, ex, rx);
    total++; if (eo !== 1'b1) begin bad++; $display("FAIL oor_err got=%b want=1", eo); end
    total++; if (lat !== WS + 1) begin bad++; $display("FAIL oor_lat got=%0d want=%0d", lat, WS + 1); end
    xfer(1, 0, 32'h0, 32'd0, 4'h0, lat, bo, eo, ro, dn, ex, rx);
    total++; if (ro !== 32'h0000_1234) begin bad++; $display("FAIL oor_word0 got=%h want=00001234", ro); end
    total++; if (eo !== 1'b0) begin bad++; $display("FAIL err_cleared got=%b want=0", eo); end
  endtask

  task automatic test_conflict();
    int lat; bit bo, ex; logic eo, dn; logic [31:0] ro, rx;
    xfer(0, 1, 32'h2C, 32'd9, 4'hF, lat, bo, eo, ro, dn, ex, rx);
    xfer(1, 1, 32'h2C, 32'd5, 4'hF, lat, bo, eo, ro, dn, ex, rx);
    total++; if (eo !== 1'b1) begin bad++; $display("FAIL rdwr_err got=%b want=1", eo); end
    xfer(1, 0, 32'h2C, 32'd0, 4'h0, lat, bo, eo, ro, dn, ex, rx);
    total++; if (ro !== 32'd9) begin bad++; $display("FAIL rdwr_nowrite got=%h want=9", ro); end
  endtask

  task automatic test_reset_mid();
    int lat; bit bo, ex; logic eo, dn; logic [31:0] ro, rx;
    xfer(0, 1, 32'hC, 32'd2, 4'hF, lat, bo, eo, ro, dn, ex, rx);
    bus.memread = 1'b0; bus.memwrite = 1'b1; bus.dataadr = 32'hC;
    bus.writedata = 32'h0C; bus.byteen = 4'hF;
    @(posedge clk);
    @(negedge clk);
    bus.memwrite = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", bus.done); end
    total++; if (bus.readdata !== 32'd0) begin bad++; $display("FAIL midrst_rdata got=%h want=0", bus.readdata); end
    reset = 1'b0;
    m_rd = 32'd0; m_cnt = 32'd0;
    repeat (WS + 2) @(negedge clk);
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL midrst_no_done got=%b want=0", bus.done); end
    xfer(1, 0, 32'hC, 32'd0, 4'h0, lat, bo, eo, ro, dn, ex, rx);
    total++; if (ro !== 32'd2) begin bad++; $display("FAIL midrst_nocommit got=%h want=2", ro); end
  endtask

  task automatic test_wrcount();
    int lat; bit bo, ex; logic eo, dn; logic [31:0] ro, rx;
`ifdef DMEM_WRCOUNT_EN
    xfer(0, 1, CSR_AD, 32'd0, 4'hF, lat, bo, eo, ro, dn, ex, rx);
    xfer(0, 1, 32'h20, 32'd1, 4'hF, lat, bo, eo, ro, dn, ex, rx);
    xfer(0, 1, 32'h24, 32'd2, 4'h0, lat, bo, eo, ro, dn, ex, rx);
    xfer(0, 1, 32'h28, 32'd3, 4'h3, lat, bo, eo, ro, dn, ex, rx);
    xfer(1, 0, CSR_AD, 32'd0, 4'h0, lat, bo, eo, ro, dn, ex, rx);
    total++; if (ro !== 32'd3) begin bad++; $display("FAIL wrcnt_val got=%h want=3", ro); end
    total++; if (eo !== 1'b0) begin bad++; $display("FAIL wrcnt_err got=%b want=0", eo); end
    xfer(0, 1, CSR_AD, 32'd0, 4'hF, lat, bo, eo, ro, dn, ex, rx);
    total++; if (eo !== 1'b0) begin bad++; $display("FAIL wrcnt_clr_err got=%b want=0", eo); end
    xfer(1, 0, CSR_AD, 32'd0, 4'h0, lat, bo, eo, ro, dn, ex, rx);
    total++; if (ro !== 32'd0) begin bad++; $display("FAIL wrcnt_clr got=%h want=0", ro); end
`else
    xfer(1, 0, CSR_AD, 32'd0, 4'h0, lat, bo, eo, ro, dn, ex, rx);
    total++; if (eo !== 1'b1) begin bad++; $display("FAIL csr_absent_err got=%b want=1", eo); end
    total++; if (ro !== 32'd0) begin bad++; $display("FAIL csr_absent_rdata got=%h want=0", ro); end
`endif
  endtask

  // Random mix of loads/stores/errors issued back to back at minimum spacing.
  task automatic test_random();
    int lat; bit bo, ex; logic eo, dn; logic [31:0] ro, rx;
    bit rd, wr; logic [31:0] adr; int sel; int nbad0;
    for (int w = 0; w < DEPTH; w++)
      xfer(0, 1, 32'(4 * w), $urandom, 4'hF, lat, bo, eo, ro, dn, ex, rx);
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 19);
      rd  = $urandom_range(0, 1) == 1;
      wr  = !rd || (sel == 0);
      adr = 32'(4 * $urandom_range(0, DEPTH - 1));
      if (sel == 1) adr = adr | 32'($urandom_range(1, 3));
      if (sel == 2) adr = $urandom | 32'h0001_0000;
      if (sel == 3) adr = CSR_AD;
      nbad0 = bad;
      xfer(rd, wr, adr, $urandom, 4'($urandom), lat, bo, eo, ro, dn, ex, rx);
      total++; if (lat !== WS + 1) begin bad++; $display("FAIL rnd_lat n=%0d got=%0d want=%0d", n, lat, WS + 1); end
      total++; if (eo !== ex) begin bad++; $display("FAIL rnd_err n=%0d adr=%h got=%b want=%b", n, adr, eo, ex); end
      total++; if (ro !== rx) begin bad++; $display("FAIL rnd_rdata n=%0d adr=%h got=%h want=%h", n, adr, ro, rx); end
      total++; if (dn !== 1'b0 || bo !== 1'b1) begin bad++; $display("FAIL rnd_hs n=%0d done2=%b busy_ok=%b want 0/1", n, dn, bo); end
      if (bad - nbad0 > 2) break;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byteen();
    test_errors();
    test_conflict();
    test_reset_mid();
    test_wrcount();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory slave that answers the processor's load/store bus (memwrite, dataadr, writedata) with a programmable wait-state handshake.
- It is the responder end of the same interface the MIPS testbench monitors. It is instantiated beside the core in top, so stores and loads now take variable latency.
- Word-addressed RAM with byte enables, per-request error flagging and a single-cycle completion strobe.

Parameters:
- DEPTH_LOG2, 6, log2 of word count (default 64 words = 256 bytes).
- WAIT_STATES, 2, idle cycles between accept and completion (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- memread  input  1  load request.
- memwrite  input  1  store request.
- dataadr  input  32  byte address.
- writedata  input  32  store data.
- byteen  input  4  store byte enables; bit i writes byte i (writedata[8i+7:8i]).
- readdata  output  32  load data, valid when done=1.
- done  output  1  one-cycle completion strobe.
- busy  output  1  high while a request is in flight.
- err  output  1  error status for the completing request, valid with done.

Behaviour:
- Reset: state=IDLE, done=0, busy=0, err=0, readdata=0, wait counter=0. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE: if memread|memwrite at a rising edge, latch dataadr, writedata, byteen and the operation. Then go to WAIT, or straight to RESP when WAIT_STATES=0. Load the counter with WAIT_STATES.
- WAIT: decrement the counter each cycle. When it reaches 1, go to RESP on the next edge. The commit happens on that edge.
- RESP: done=1 for exactly one cycle, then return to IDLE.
- Latency: accept edge to done rising is WAIT_STATES+1 cycles.
- busy = (state != IDLE).
- Request inputs are ignored outside IDLE; latched values are used for the whole request.
- Requester rule: deassert requests in the cycle after done. Any request present in IDLE is accepted, including a repeat.
- Address decode: word index = adr[DEPTH_LOG2+1:2].
  - Error if adr[31:DEPTH_LOG2+2] != 0 (out of range).
  - Error if adr[1:0] != 0 (misaligned).
  - Error if memread and memwrite are both high at accept.
- On error: no RAM write, readdata=0, err=1 with done.
- Commit edge (entering RESP):
  - Store: write only the enabled bytes. byteen=0 is a legal no-op, err=0.
  - Load: readdata registered from RAM.
- readdata holds its value until the next load or error completion. Stores do not change readdata.
- err is cleared when the next request is accepted.
- Reset mid-request: abort. No commit if reset is high on the commit edge. Outputs return to reset values.
- Back-to-back: the minimum request spacing is WAIT_STATES+2 cycles (accept, waits, RESP, IDLE).

Optional Feature:
- Macro: DMEM_WRCOUNT_EN.
- Defined:
  - A 32-bit store counter, reset to 0, increments on every committed non-error store (byteen may be 0). It wraps from 0xFFFFFFFF to 0.
  - A load from address 0xFFFFFFF0 returns the counter, err=0.
  - A store to 0xFFFFFFF0 clears the counter, err=0. The clearing store itself is not counted.
- Not defined: 0xFFFFFFF0 decodes as out of range (err=1). No counter logic is synthesised.

Test Plan:
- WAIT_STATES=2: store 21 to 0x14 with byteen=4'hF, then load 0x14 -> done exactly 3 cycles after each accept, readdata=21, err=0.
- Byte enables: store 0x550000FF to 0x18, then store 0xAABBCCDD with byteen=4'b0100, then load -> readdata=0x55BB00FF.
- Errors:
  - Load 0x00000102 (misaligned) -> err=1, readdata=0.
  - Store 7 to 0x00000400 (out of range for DEPTH_LOG2=6) -> err=1; a subsequent load of word 0 is unchanged.
- Simultaneous memread and memwrite to 0x2C holding 9 -> err=1, and a later load of 0x2C still returns 9.
- Reset asserted during WAIT of a store of 0x0C to 0xC, where 0xC previously held 2 -> busy=0 and done=0 next cycle; reloading 0xC returns 2.
- Feature builds:
  - With DMEM_WRCOUNT_EN: 3 stores, then load 0xFFFFFFF0 -> readdata=3; store to 0xFFFFFFF0, then load -> readdata=0.
  - Without DMEM_WRCOUNT_EN: the same load gives err=1.
  - WAIT_STATES=0 build: done 1 cycle after accept.
